// File: rtl/cpu_datapath.sv
// Datapath for the simple CPU: 8-entry register file, A/B operand registers,
// shifter, ALU, the C result register and the Z/N/V status register.
module cpu_datapath #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   readnum,
  input  logic [2:0]   writenum,
  input  logic         write,
  input  logic [1:0]   vsel,
  input  logic         loada,
  input  logic         loadb,
  input  logic         asel,
  input  logic         bsel,
  input  logic [1:0]   shift,
  input  logic [1:0]   ALUop,
  input  logic         loadc,
  input  logic         loads,
  input  logic [W-1:0] sximm5,
  input  logic [W-1:0] sximm8,
  input  logic [W-1:0] mdata,
  output logic [W-1:0] datapath_out,
  output logic         Z_out,
  output logic         N_out,
  output logic         V_out
);

  logic [W-1:0] regs [8];
  logic [W-1:0] areg, breg, creg;
  logic [2:0]   status;

  logic [W-1:0] rdata, wdata, sout, ain, bin, alures;
  logic         zflag, nflag, vflag;

  // Register-file read has no bypass: a same-cycle write is seen only next cycle.
  always_comb begin
    rdata = regs[readnum];
  end

  always_comb begin
    case (vsel)
      2'b00:   wdata = creg;
      2'b01:   wdata = sximm8;
      2'b10:   wdata = mdata;
      default: wdata = '0;
    endcase
  end

  always_comb begin
    case (shift)
      2'b00:   sout = breg;
      2'b01:   sout = {breg[W-2:0], 1'b0};
      2'b10:   sout = {1'b0, breg[W-1:1]};
      default: sout = {breg[W-1], breg[W-1:1]};
    endcase
  end

  always_comb begin
    ain = asel ? '0 : areg;
    bin = bsel ? sximm5 : sout;
  end

  // Overflow is only meaningful for add/sub; logical ops always clear it.
  always_comb begin
    alures = '0;
    vflag  = 1'b0;
    case (ALUop)
      2'b00: begin
        alures = ain + bin;
        vflag  = (ain[W-1] == bin[W-1]) && (alures[W-1] != ain[W-1]);
      end
      2'b01: begin
        alures = ain - bin;
        vflag  = (ain[W-1] != bin[W-1]) && (alures[W-1] != ain[W-1]);
      end
      2'b10: alures = ain & bin;
      default: alures = ~bin;
    endcase
    zflag = (alures == '0);
    nflag = alures[W-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      areg   <= '0;
      breg   <= '0;
      creg   <= '0;
      status <= '0;
    end else begin
      if (write) regs[writenum] <= wdata;
      if (loada) areg <= rdata;
      if (loadb) breg <= rdata;
      if (loadc) creg <= alures;
      if (loads) status <= {zflag, nflag, vflag};
    end
  end

  assign datapath_out = creg;
  assign Z_out        = status[2];
  assign N_out        = status[1];
  assign V_out        = status[0];

endmodule

// File: tb/tb_cpu_datapath.sv
// Scoreboard bench for cpu_datapath: an integer-arithmetic reference model
// predicts C and the flags after every clock; a monitor compares on negedge.
module tb_cpu_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  readnum, writenum;
  logic        write;
  logic [1:0]  vsel;
  logic        loada, loadb, asel, bsel;
  logic [1:0]  shift, ALUop;
  logic        loadc, loads;
  logic [15:0] sximm5, sximm8, mdata;
  logic [15:0] datapath_out;
  logic        Z_out, N_out, V_out;

  int checks = 0;
  int errors = 0;
  logic [18:0] expq [$];

  int unsigned mr [8];
  int unsigned ma, mb, mc;
  bit          mz, mn, mv;

  cpu_datapath #(.W(16)) dut (
    .clk(clk), .reset(reset), .readnum(readnum), .writenum(writenum),
    .write(write), .vsel(vsel), .loada(loada), .loadb(loadb), .asel(asel),
    .bsel(bsel), .shift(shift), .ALUop(ALUop), .loadc(loadc), .loads(loads),
    .sximm5(sximm5), .sximm8(sximm8), .mdata(mdata),
    .datapath_out(datapath_out), .Z_out(Z_out), .N_out(N_out), .V_out(V_out)
  );

  always #5 clk = ~clk;

  function automatic int sgn(input int unsigned x);
    return (x >= 32768) ? int'(x) - 65536 : int'(x);
  endfunction

  // Reference model: evaluates one clock edge from the current inputs, using old state.
  task automatic modelStep();
    int unsigned rd, wd, sv, a, b, res;
    int s;
    bit v;
    if (reset) begin
      for (int i = 0; i < 8; i++) mr[i] = 0;
      ma = 0; mb = 0; mc = 0; mz = 0; mn = 0; mv = 0;
      return;
    end
    rd = mr[readnum];
    case (vsel)
      2'd0: wd = mc;
      2'd1: wd = sximm8;
      2'd2: wd = mdata;
      default: wd = 0;
    endcase
    case (shift)
      2'd0: sv = mb;
      2'd1: sv = (mb * 2) % 65536;
      2'd2: sv = mb / 2;
      default: sv = mb / 2 + ((mb >= 32768) ? 32768 : 0);
    endcase
    a = asel ? 0 : ma;
    b = bsel ? int'(sximm5) : sv;
    v = 0;
    case (ALUop)
      2'd0: begin res = (a + b) % 65536; s = sgn(a) + sgn(b); v = (s > 32767) || (s < -32768); end
      2'd1: begin res = (a + 65536 - b) % 65536; s = sgn(a) - sgn(b); v = (s > 32767) || (s < -32768); end
      2'd2: res = a & b;
      default: res = 65535 - b;
    endcase
    if (write) mr[writenum] = wd;
    if (loada) ma = rd;
    if (loadb) mb = rd;
    if (loadc) mc = res;
    if (loads) begin mz = (res == 0); mn = (res >= 32768); mv = v; end
  endtask

  task automatic idle();
    reset = 0; readnum = 0; writenum = 0; write = 0; vsel = 0;
    loada = 0; loadb = 0; asel = 0; bsel = 0; shift = 0; ALUop = 0;
    loadc = 0; loads = 0; sximm5 = 0; sximm8 = 0; mdata = 0;
  endtask

  // Clocks the currently driven control word and queues the predicted outputs.
  task automatic applyStimulus();
    logic [15:0] c16;
    @(posedge clk);
    modelStep();
    c16 = mc[15:0];
    expq.push_back({c16, mz, mn, mv});
    #1;
    idle();
  endtask

  task automatic checkOutput(input logic [18:0] exp);
    logic [18:0] act;
    act = {datapath_out, Z_out, N_out, V_out};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL cycle_check #%0d: got out=%h ZNV=%b, expected out=%h ZNV=%b",
               checks, act[18:3], act[2:0], exp[18:3], exp[2:0]);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) checkOutput(expq.pop_front());
  end

  task automatic randomCycle();
    idle();
    reset    = ($urandom_range(0, 59) == 0);
    readnum  = 3'($urandom_range(0, 7));
    writenum = 3'($urandom_range(0, 7));
    write    = 1'($urandom_range(0, 1));
    vsel     = 2'($urandom_range(0, 3));
    loada    = 1'($urandom_range(0, 1));
    loadb    = 1'($urandom_range(0, 1));
    asel     = ($urandom_range(0, 3) == 0);
    bsel     = ($urandom_range(0, 3) == 0);
    shift    = 2'($urandom_range(0, 3));
    ALUop    = 2'($urandom_range(0, 3));
    loadc    = ($urandom_range(0, 3) != 0);
    loads    = 1'($urandom_range(0, 1));
    sximm5   = {{11{1'($urandom_range(0, 1))}}, 5'($urandom_range(0, 31))};
    sximm8   = {{8{1'($urandom_range(0, 1))}}, 8'($urandom_range(0, 255))};
    case ($urandom_range(0, 3))
      0: mdata = 16'h7FFF;
      1: mdata = 16'h8000;
      default: mdata = 16'($urandom());
    endcase
  endtask

  initial begin
    idle();
    // Reset with every load/write asserted: all must be ignored.
    reset = 1; loadc = 1; loads = 1; write = 1; vsel = 2'd1; sximm8 = 16'h1234; applyStimulus();
    vsel = 2'd1; sximm8 = 16'h0007; writenum = 0; write = 1; applyStimulus();
    vsel = 2'd1; sximm8 = 16'h0002; writenum = 1; write = 1; applyStimulus();
    // R2 = R1 << 1 through the ALU and C write-back
    readnum = 1; loadb = 1; applyStimulus();
    shift = 2'd1; asel = 1; ALUop = 2'd0; loadc = 1; applyStimulus();
    vsel = 2'd0; writenum = 2; write = 1; applyStimulus();
    // 7 - 4, then 4 - 4
    readnum = 0; loada = 1; applyStimulus();
    readnum = 2; loadb = 1; applyStimulus();
    ALUop = 2'd1; loadc = 1; loads = 1; applyStimulus();
    readnum = 2; loada = 1; applyStimulus();
    ALUop = 2'd1; loadc = 1; loads = 1; applyStimulus();
    // 0x7FFF + 1 overflows
    mdata = 16'h7FFF; vsel = 2'd2; writenum = 3; write = 1; applyStimulus();
    readnum = 3; loada = 1; applyStimulus();
    sximm5 = 16'h0001; bsel = 1; ALUop = 2'd0; loadc = 1; loads = 1; applyStimulus();
    // Shifter on 0x8000 and NOT of R0
    mdata = 16'h8000; vsel = 2'd2; writenum = 4; write = 1; applyStimulus();
    readnum = 4; loadb = 1; applyStimulus();
    shift = 2'd3; asel = 1; loadc = 1; loads = 1; applyStimulus();
    shift = 2'd2; asel = 1; loadc = 1; loads = 1; applyStimulus();
    readnum = 0; loadb = 1; applyStimulus();
    ALUop = 2'd3; loadc = 1; loads = 1; applyStimulus();
    // Same-index write/read: A must capture the old R0
    readnum = 0; loada = 1; writenum = 0; write = 1; vsel = 2'd1; sximm8 = 16'h0055; applyStimulus();
    bsel = 1; sximm5 = 16'h0000; ALUop = 2'd0; loadc = 1; loads = 1; applyStimulus();
    vsel = 2'd3; writenum = 0; write = 1; applyStimulus();
    readnum = 0; loada = 1; applyStimulus();
    bsel = 1; sximm5 = 16'h0003; loadc = 1; loads = 1; applyStimulus();
    // Reset mid-run with loads/writes asserted
    reset = 1; loadc = 1; loads = 1; write = 1; loada = 1; loadb = 1; applyStimulus();
    readnum = 1; loada = 1; applyStimulus();
    bsel = 1; sximm5 = 16'h0000; loadc = 1; loads = 1; applyStimulus();

    for (int n = 0; n < 500; n++) begin
      randomCycle();
      applyStimulus();
    end

    repeat (3) @(posedge clk);
    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
